// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding, default parameters and a small index helper.
package axi_xbar_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arbState_t;

    localparam int         DEFAULT_NUM_REQ      = 5;
    localparam logic [4:0] DEFAULT_PRIO_MASK    = 5'b00001;
    localparam int         DEFAULT_WEIGHT_BITS  = 4;
    localparam int         DEFAULT_STARVE_LIMIT = 64;

    // Next index around a ring of the given size.
    function automatic int wrapInc(input int value, input int modulus);
        return (value + 1) % modulus;
    endfunction

endpackage

// File: rtl/axi_xbar_rr_pick.sv
// Combinational masked find-first: scans reqs&mask starting at i_start, wrapping around,
// and returns the first hit as one-hot and binary index.
module axi_xbar_rr_pick #(
    parameter int NUM_REQ  = 5,
    parameter int IDX_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_reqs,
    input  logic [NUM_REQ-1:0]  i_mask,
    input  logic [IDX_BITS-1:0] i_start,
    output logic [NUM_REQ-1:0]  o_oneHot,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_found
);

    logic [NUM_REQ-1:0] w_masked;

    assign w_masked = i_reqs & i_mask;

    always_comb begin
        o_oneHot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_found && w_masked[(int'(i_start) + k) % NUM_REQ]) begin
                o_found                                  = 1'b1;
                o_oneHot[(int'(i_start) + k) % NUM_REQ]  = 1'b1;
                o_idx                                    = IDX_BITS'((int'(i_start) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/axi_xbar_wrr_arb.sv
// Weighted round-robin crossbar arbiter with strict-priority requesters and starvation promotion.
// A grant is held for weight+1 completed transactions and never changes mid-transaction.
module axi_xbar_wrr_arb
    import axi_xbar_pkg::*;
#(
    parameter int                 NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int                 IDX_BITS     = $clog2(NUM_REQ),
    parameter logic [NUM_REQ-1:0] PRIO_MASK    = NUM_REQ'(DEFAULT_PRIO_MASK),
    parameter int                 WEIGHT_BITS  = DEFAULT_WEIGHT_BITS,
    parameter int                 STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             reqs,
    input  logic [NUM_REQ*WEIGHT_BITS-1:0] weights,
    input  logic                           accept,
    input  logic                           last,
    output logic                           grant_valid,
    output logic [NUM_REQ-1:0]             grant_b,
    output logic [IDX_BITS-1:0]            grant_i
);

    localparam int CREDIT_W = WEIGHT_BITS + 1;
    localparam int WAIT_W   = $clog2(STARVE_LIMIT + 1);

    arbState_t             r_state, w_nextState;
    logic [NUM_REQ-1:0]    r_grantB, w_nextGrantB;
    logic [IDX_BITS-1:0]   r_grantI, w_nextGrantI;
    logic [IDX_BITS-1:0]   r_rrPtr, w_nextRrPtr, w_rrBase, w_rrStart;
    logic [CREDIT_W-1:0]   r_credit, w_nextCredit;
    logic [WAIT_W-1:0]     r_wait [NUM_REQ];

    logic [NUM_REQ-1:0]    w_waitSat, w_exclude, w_cand;
    logic                  w_release, w_holderPrio;
    logic [NUM_REQ-1:0]    w_promB, w_prioB, w_rrB, w_winB;
    logic [IDX_BITS-1:0]   w_promI, w_prioI, w_rrI, w_winI;
    logic                  w_promFound, w_prioFound, w_rrFound, w_winFound;
    logic [WEIGHT_BITS-1:0] w_winWeight;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_waitSat[k] = (r_wait[k] == WAIT_W'(STARVE_LIMIT));
        end
    end

    // The releasing holder sits out the arbitration it triggers.
    assign w_exclude    = (r_state == ST_HOLD) ? r_grantB : '0;
    assign w_cand       = reqs & ~w_exclude;
    assign w_holderPrio = |(r_grantB & PRIO_MASK);
    assign w_rrBase     = (r_state == ST_HOLD && !w_holderPrio) ? r_grantI : r_rrPtr;
    assign w_rrStart    = IDX_BITS'(wrapInc(int'(w_rrBase), NUM_REQ));

    axi_xbar_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pickProm (
        .i_reqs(w_cand), .i_mask(w_waitSat), .i_start('0),
        .o_oneHot(w_promB), .o_idx(w_promI), .o_found(w_promFound)
    );

    axi_xbar_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pickPrio (
        .i_reqs(w_cand), .i_mask(PRIO_MASK), .i_start('0),
        .o_oneHot(w_prioB), .o_idx(w_prioI), .o_found(w_prioFound)
    );

    axi_xbar_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_BITS(IDX_BITS)) u_pickRr (
        .i_reqs(w_cand), .i_mask(~PRIO_MASK), .i_start(w_rrStart),
        .o_oneHot(w_rrB), .o_idx(w_rrI), .o_found(w_rrFound)
    );

    assign w_winFound  = w_promFound | w_prioFound | w_rrFound;
    assign w_winB      = w_promFound ? w_promB : (w_prioFound ? w_prioB : w_rrB);
    assign w_winI      = w_promFound ? w_promI : (w_prioFound ? w_prioI : w_rrI);
    assign w_winWeight = weights[int'(w_winI)*WEIGHT_BITS +: WEIGHT_BITS];

    assign w_release = (r_state == ST_HOLD) &&
                       ((accept && last && r_credit == CREDIT_W'(1)) || (!reqs[r_grantI] && !accept));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grantB <= '0;
            r_grantI <= '0;
            r_rrPtr  <= IDX_BITS'(NUM_REQ - 1);
            r_credit <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                r_wait[k] <= '0;
            end
        end else begin
            r_state  <= w_nextState;
            r_grantB <= w_nextGrantB;
            r_grantI <= w_nextGrantI;
            r_rrPtr  <= w_nextRrPtr;
            r_credit <= w_nextCredit;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!reqs[k] || w_nextGrantB[k]) begin
                    r_wait[k] <= '0;
                end else if (!r_grantB[k] && !w_waitSat[k]) begin
                    r_wait[k] <= r_wait[k] + WAIT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE: if (w_winFound) w_nextState = ST_HOLD;
            ST_HOLD: if (w_release)  w_nextState = w_winFound ? ST_HOLD : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // A fresh grant reloads credit; a continuing hold spends one credit per finished transaction.
    always_comb begin
        w_nextGrantB = r_grantB;
        w_nextGrantI = r_grantI;
        w_nextCredit = r_credit;
        w_nextRrPtr  = r_rrPtr;
        if (w_release && !w_holderPrio) begin
            w_nextRrPtr = r_grantI;
        end
        if (w_nextState == ST_HOLD && (r_state == ST_IDLE || w_release)) begin
            w_nextGrantB = w_winB;
            w_nextGrantI = w_winI;
            w_nextCredit = {1'b0, w_winWeight} + CREDIT_W'(1);
        end else if (w_nextState == ST_IDLE) begin
            w_nextGrantB = '0;
            w_nextCredit = '0;
        end else if (accept && last) begin
            w_nextCredit = r_credit - CREDIT_W'(1);
        end
    end

    assign grant_valid = (r_state == ST_HOLD);
    assign grant_b     = r_grantB;
    assign grant_i     = r_grantI;

endmodule

// File: tb/tb_axi_xbar_wrr_arb.sv
// Directed bench for the weighted round-robin arbiter: alternation, weighting, bursts,
// drop release, starvation promotion and asynchronous reset.
module tb_axi_xbar_wrr_arb;

    localparam int NUM_REQ      = 5;
    localparam int IDX_BITS     = 3;
    localparam int WEIGHT_BITS  = 4;
    localparam int STARVE_LIMIT = 8;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             reqs;
    logic [NUM_REQ*WEIGHT_BITS-1:0] weights;
    logic                           accept;
    logic                           last;
    logic                           grant_valid;
    logic [NUM_REQ-1:0]             grant_b;
    logic [IDX_BITS-1:0]            grant_i;

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;

    axi_xbar_wrr_arb #(
        .NUM_REQ(NUM_REQ),
        .IDX_BITS(IDX_BITS),
        .PRIO_MASK(5'b00001),
        .WEIGHT_BITS(WEIGHT_BITS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reqs(reqs),
        .weights(weights),
        .accept(accept),
        .last(last),
        .grant_valid(grant_valid),
        .grant_b(grant_b),
        .grant_i(grant_i)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic a, input logic l);
        reqs   = r;
        accept = a;
        last   = l;
    endtask

    task automatic setWeight(input int idx, input logic [WEIGHT_BITS-1:0] w);
        weights[idx*WEIGHT_BITS +: WEIGHT_BITS] = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdx(input string tag, input int expIdx);
        checksTotal++;
        assert (grant_i === IDX_BITS'(expIdx)) checksPassed++;
        else begin
            checksFailed++;
            $error("FAIL %s grant_i: observed %0d expected %0d", tag, grant_i, expIdx);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input int expIdx);
        logic [NUM_REQ-1:0] expB;
        expB = expValid ? (NUM_REQ'(1) << expIdx) : '0;
        checksTotal++;
        assert (grant_valid === expValid) checksPassed++;
        else begin
            checksFailed++;
            $error("FAIL %s grant_valid: observed %0b expected %0b", tag, grant_valid, expValid);
        end
        checksTotal++;
        assert (grant_b === expB) checksPassed++;
        else begin
            checksFailed++;
            $error("FAIL %s grant_b: observed %05b expected %05b", tag, grant_b, expB);
        end
        if (expValid) checkIdx(tag, expIdx);
    endtask

    initial begin
        int altSeq[4]    = '{1, 2, 1, 2};
        int weightSeq[6] = '{1, 1, 1, 1, 2, 1};

        rst_n   = 1'b1;
        weights = '0;
        applyStimulus(5'b00000, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 0);
        checkIdx("resetIdx", 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idleNoReq", 1'b0, 0);

        // Equal weights: alternate every accepted transfer with no bubble
        applyStimulus(5'b00110, 1'b1, 1'b1);
        foreach (altSeq[k]) begin
            tick();
            checkOutput($sformatf("alt%0d", k), 1'b1, altSeq[k]);
        end

        // Requester 1 gets a quantum of four transfers
        setWeight(1, 4'd3);
        foreach (weightSeq[k]) begin
            tick();
            checkOutput($sformatf("wrr%0d", k), 1'b1, weightSeq[k]);
        end

        applyStimulus(5'b00000, 1'b0, 1'b0);
        tick();
        checkOutput("dropAll", 1'b0, 0);

        // Burst from requester 2 is not interrupted by priority requester 0
        applyStimulus(5'b00100, 1'b0, 1'b0);
        tick();
        checkOutput("burstStart", 1'b1, 2);
        applyStimulus(5'b00101, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick();
            checkOutput($sformatf("burst%0d", k), 1'b1, 2);
        end
        applyStimulus(5'b00101, 1'b1, 1'b1);
        tick();
        checkOutput("burstEnd", 1'b1, 0);

        // Holder drops request without accept; next requester takes over, then idle
        applyStimulus(5'b01000, 1'b0, 1'b0);
        tick();
        checkOutput("dropHand", 1'b1, 3);
        applyStimulus(5'b00000, 1'b0, 1'b0);
        tick();
        checkOutput("drop3Idle", 1'b0, 0);

        // Long hold by 3 starves 1, which is then promoted above priority requester 0
        setWeight(3, 4'd15);
        applyStimulus(5'b01000, 1'b0, 1'b0);
        tick();
        checkOutput("longStart", 1'b1, 3);
        applyStimulus(5'b01010, 1'b1, 1'b1);
        for (int k = 0; k < 14; k++) begin
            tick();
            checkOutput($sformatf("long%0d", k), 1'b1, 3);
        end
        applyStimulus(5'b01011, 1'b1, 1'b1);
        tick();
        checkOutput("longLast", 1'b1, 3);
        tick();
        checkOutput("promote", 1'b1, 1);

        // Asynchronous reset in the middle of a burst
        applyStimulus(5'b00011, 1'b1, 1'b0);
        tick();
        checkOutput("preReset", 1'b1, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 1'b0, 0);
        checkIdx("asyncResetIdx", 0);
        applyStimulus(5'b10000, 1'b0, 1'b0);
        tick();
        checkOutput("inReset", 1'b0, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("postReset", 1'b1, 4);
        applyStimulus(5'b00000, 1'b0, 1'b0);
        tick();
        checkOutput("finalIdle", 1'b0, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/axi_xbar_wrr_arb.md
AXI_XBAR_WRR_ARB -- requirements
Module: axi_xbar_wrr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 5, number of requesters (2..16).
REQ-002 SHALL have parameter IDX_BITS, default $clog2(NUM_REQ), grant index width.
REQ-003 SHALL have parameter PRIO_MASK, default 5'b00001 (NUM_REQ bits), requesters with strict priority.
REQ-004 SHALL have parameter WEIGHT_BITS, default 4, per-requester weight width.
REQ-005 SHALL have parameter STARVE_LIMIT, default 64, wait cycles before a non-priority requester is promoted.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port clk, input, 1, the clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port reqs, input, NUM_REQ, per-requester valid.
REQ-010 SHALL have port weights, input, NUM_REQ*WEIGHT_BITS, per-requester quantum minus one, quasi-static.
REQ-011 SHALL have port accept, input, 1, valid&&ready on the granted channel this cycle.
REQ-012 SHALL have port last, input, 1, the accepted beat ends a transaction.
REQ-013 SHALL have port grant_valid, output, 1, a grant is held.
REQ-014 SHALL have port grant_b, output, NUM_REQ, one-hot grant (all zero when grant_valid=0).
REQ-015 SHALL have port grant_i, output, IDX_BITS, binary grant index.

Function
REQ-016 SHALL implement states IDLE (grant_valid=0) and HOLD (grant_valid=1); all outputs registered.
REQ-017 In IDLE with any reqs bit set, SHALL enter HOLD at the next edge with the winner; grant latency is 1 cycle.
REQ-018 Winner selection order SHALL be: promoted (starved) requesters, then PRIO_MASK requesters, then the rest; the lowest index wins within each of the first two classes.
REQ-019 Within the non-priority class, SHALL use round-robin starting at index rr_ptr+1 mod NUM_REQ.
REQ-020 On entering HOLD, SHALL load credit = weights[winner]+1 (width WEIGHT_BITS+1).
REQ-021 In HOLD, SHALL decrement credit on every cycle with accept && last.
REQ-022 Release SHALL occur when credit reaches zero, or when reqs[grant_i]=0 while accept=0.
REQ-023 On release, SHALL set rr_ptr <= grant_i if the holder is non-priority.
REQ-024 On release with other requests pending, SHALL go HOLD→HOLD with the new winner at the same edge (no bubble); the releasing requester is excluded from that arbitration.
REQ-025 On release with no other requests pending, SHALL go to IDLE.
REQ-026 SHALL never change grant mid-transaction: accept && !last never causes a release.
REQ-027 Priority requesters SHALL NOT preempt a held grant; they win at the next release.
REQ-028 SHALL keep a per-requester wait counter, saturating at STARVE_LIMIT, incremented while requesting and not granted, cleared on grant or when the request drops.
REQ-029 A requester whose wait counter equals STARVE_LIMIT SHALL be promoted.
REQ-030 Simultaneous release and new requests SHALL be resolved using reqs sampled in the release cycle.

Reset
REQ-031 Asserting rst_n low SHALL immediately force IDLE, grant_valid=0, grant_b=0, grant_i=0, rr_ptr=NUM_REQ-1, credit=0 and all wait counters to 0, including mid-transaction.
REQ-032 After reset deassertion, the first grant SHALL follow REQ-017.

Structure
REQ-033 SHALL place the state enum and the default PRIO_MASK/WEIGHT_BITS constants in the shared axi_xbar_pkg package.
REQ-034 SHALL use one sub-module, axi_xbar_rr_pick: combinational masked round-robin find-first (reqs, mask, start pointer → one-hot and index).
REQ-035 SHALL be a drop-in replacement for the existing AW/AR arbiters in the crossbar, with accept=mi valid&&ready and last=1 for address channels.

Verification
REQ-036 reqs=5'b00110, weights=0, last=1, accept every cycle → grants 1,2,1,2… with one grant per cycle and no idle bubble.
REQ-037 reqs=5'b00110, weights[1]=3, weights[2]=0 → requester 1 holds for 4 accepted transfers, then requester 2 holds for 1, repeating.
REQ-038 Requester 2 holding a burst (accept with last=0 for 7 beats) while reqs[0] rises → grant stays 2 until the beat with last=1, then requester 0 is granted on the next edge.
REQ-039 reqs=5'b00011 held constant, STARVE_LIMIT=8, requester 0 re-requests continuously → requester 1 is granted within 8 waiting cycles plus the current transaction.
REQ-040 Reset asserted in HOLD mid-burst → grant_valid=0 and grant_b=0 without waiting for a clock edge; after release with reqs=5'b10000, grant_i=4 one cycle later.
REQ-041 Requester 3 drops reqs while granted with accept=0 → release; with no other requests, IDLE and grant_b=0 at the next edge.
